// File: rtl/overdrive_atten_ctrl.sv
//------------------------------------------------------------------------------
// Module      : overdrive_atten_ctrl
// Description : Closed-loop step-attenuator controller driven by the RX overdrive
//               flag; fast attack, settle holdoff, slow one-code release.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module overdrive_atten_ctrl #(
    parameter int ATTEN_BITS     = 5,
    parameter int MAX_ATTEN      = 31,
    parameter int STEP_UP        = 2,
    parameter int HOLDOFF_CYCLES = 1024,
    parameter int RELEASE_CYCLES = 65536
) (
    input  logic                  i_clk,
    input  logic                  i_resetn,
    input  logic                  i_overdrive,
    input  logic                  i_valid,
    input  logic                  i_enable,
    input  logic [ATTEN_BITS-1:0] i_manual_atten,
    output logic [ATTEN_BITS-1:0] o_atten,
    output logic                  o_atten_update,
    output logic                  o_at_max,
    output logic [1:0]            o_state
);

    localparam int c_REL_W  = $clog2(RELEASE_CYCLES);
    localparam int c_HOLD_W = $clog2(HOLDOFF_CYCLES) + 1;

    localparam logic [1:0] c_ST_MANUAL = 2'b00;
    localparam logic [1:0] c_ST_TRACK  = 2'b01;
    localparam logic [1:0] c_ST_SETTLE = 2'b10;

    localparam logic [ATTEN_BITS-1:0] c_MAX       = ATTEN_BITS'(MAX_ATTEN);
    localparam logic [ATTEN_BITS:0]   c_MAX_WIDE  = (ATTEN_BITS+1)'(MAX_ATTEN);
    localparam logic [ATTEN_BITS:0]   c_STEP_WIDE = (ATTEN_BITS+1)'(STEP_UP);
    localparam logic [ATTEN_BITS-1:0] c_ONE       = ATTEN_BITS'(1);
    localparam logic [c_REL_W-1:0]    c_REL_LAST  = c_REL_W'(RELEASE_CYCLES - 1);
    localparam logic [c_REL_W-1:0]    c_REL_ONE   = c_REL_W'(1);
    localparam logic [c_HOLD_W-1:0]   c_HOLD_LOAD = c_HOLD_W'(HOLDOFF_CYCLES - 1);
    localparam logic [c_HOLD_W-1:0]   c_HOLD_ONE  = c_HOLD_W'(1);

    logic [1:0]            r_state, w_state_nxt;
    logic [ATTEN_BITS-1:0] r_atten, w_atten_nxt;
    logic                  r_update;
    logic                  r_at_max, w_at_max_nxt;
    logic [c_REL_W-1:0]    r_rel, w_rel_nxt;
    logic [c_HOLD_W-1:0]   r_hold, w_hold_nxt;

    logic                  w_event;
    logic [ATTEN_BITS-1:0] w_manual_clamped;
    logic [ATTEN_BITS:0]   w_atten_inc;
    logic [ATTEN_BITS-1:0] w_atten_up;

    assign w_event          = i_valid & i_overdrive;
    assign w_manual_clamped = (i_manual_atten > c_MAX) ? c_MAX : i_manual_atten;
    // One extra bit so the step can never wrap before saturation.
    assign w_atten_inc      = {1'b0, r_atten} + c_STEP_WIDE;
    assign w_atten_up       = (w_atten_inc > c_MAX_WIDE) ? c_MAX : w_atten_inc[ATTEN_BITS-1:0];

    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_state  <= c_ST_MANUAL;
            r_atten  <= '0;
            r_update <= 1'b0;
            r_at_max <= 1'b0;
            r_rel    <= '0;
            r_hold   <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_atten  <= w_atten_nxt;
            r_update <= (w_atten_nxt != r_atten);
            r_at_max <= w_at_max_nxt;
            r_rel    <= w_rel_nxt;
            r_hold   <= w_hold_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_atten_nxt  = r_atten;
        w_at_max_nxt = r_at_max;
        w_rel_nxt    = r_rel;
        w_hold_nxt   = r_hold;
        // Dropping enable wins over any event or release in the same cycle.
        if (!i_enable) begin
            w_state_nxt  = c_ST_MANUAL;
            w_atten_nxt  = w_manual_clamped;
            w_at_max_nxt = 1'b0;
            w_rel_nxt    = '0;
            w_hold_nxt   = '0;
        end else begin
            case (r_state)
                c_ST_MANUAL: begin
                    w_state_nxt  = c_ST_TRACK;
                    w_at_max_nxt = 1'b0;
                    w_rel_nxt    = '0;
                    w_hold_nxt   = '0;
                end
                c_ST_TRACK: begin
                    if (w_event) begin
                        w_rel_nxt = '0;
                        if (r_atten >= c_MAX) begin
                            w_at_max_nxt = 1'b1;
                        end else begin
                            w_atten_nxt = w_atten_up;
                            w_hold_nxt  = c_HOLD_LOAD;
                            w_state_nxt = c_ST_SETTLE;
                        end
                    end else if (r_rel == c_REL_LAST) begin
                        // At code 0 the counter simply stays saturated.
                        if (r_atten != '0) begin
                            w_atten_nxt  = r_atten - c_ONE;
                            w_at_max_nxt = 1'b0;
                            w_rel_nxt    = '0;
                            w_hold_nxt   = c_HOLD_LOAD;
                            w_state_nxt  = c_ST_SETTLE;
                        end
                    end else begin
                        w_rel_nxt = r_rel + c_REL_ONE;
                    end
                end
                c_ST_SETTLE: begin
                    if (r_hold == '0) begin
                        w_state_nxt = c_ST_TRACK;
                        w_rel_nxt   = '0;
                    end else begin
                        w_hold_nxt = r_hold - c_HOLD_ONE;
                    end
                end
                default: begin
                    w_state_nxt = c_ST_MANUAL;
                    w_rel_nxt   = '0;
                    w_hold_nxt  = '0;
                end
            endcase
        end
    end

    always_comb begin
        o_state        = r_state;
        o_atten        = r_atten;
        o_atten_update = r_update;
        o_at_max       = r_at_max;
    end

endmodule

`default_nettype wire

// File: tb/tb_overdrive_atten_ctrl.sv
//------------------------------------------------------------------------------
// Module      : tb_overdrive_atten_ctrl
// Description : Self-checking bench for overdrive_atten_ctrl with a cycle model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_overdrive_atten_ctrl;

    localparam int c_AB   = 5;
    localparam int c_MAX  = 7;
    localparam int c_STEP = 2;
    localparam int c_HOLD = 4;
    localparam int c_REL  = 16;

    logic            clk = 1'b0;
    logic            resetn;
    logic            overdrive;
    logic            valid;
    logic            enable;
    logic [c_AB-1:0] manual_atten;
    logic [c_AB-1:0] atten;
    logic            atten_update;
    logic            at_max;
    logic [1:0]      state;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Model state: mode 0 manual / 1 track / 2 settle
    int m_mode, m_atten, m_quiet, m_settle, m_atmax, m_upd;

    overdrive_atten_ctrl #(
        .ATTEN_BITS    (c_AB),
        .MAX_ATTEN     (c_MAX),
        .STEP_UP       (c_STEP),
        .HOLDOFF_CYCLES(c_HOLD),
        .RELEASE_CYCLES(c_REL)
    ) dut (
        .i_clk         (clk),
        .i_resetn      (resetn),
        .i_overdrive   (overdrive),
        .i_valid       (valid),
        .i_enable      (enable),
        .i_manual_atten(manual_atten),
        .o_atten       (atten),
        .o_atten_update(atten_update),
        .o_at_max      (at_max),
        .o_state       (state)
    );

    always #5 clk = ~clk;

    function automatic int min2(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_step(input bit rstn, input bit en, input bit vld, input bit od, input int man);
        int prev;
        prev = m_atten;
        if (!rstn) begin
            m_mode = 0; m_atten = 0; m_quiet = 0; m_settle = 0; m_atmax = 0; m_upd = 0;
            return;
        end
        if (!en) begin
            m_mode = 0; m_atten = min2(man, c_MAX); m_quiet = 0; m_atmax = 0;
        end else if (m_mode == 0) begin
            m_mode = 1; m_quiet = 0;
        end else if (m_mode == 2) begin
            m_settle = m_settle - 1;
            if (m_settle == 0) begin
                m_mode = 1; m_quiet = 0;
            end
        end else if (vld && od) begin
            m_quiet = 0;
            if (m_atten < c_MAX) begin
                m_atten = min2(m_atten + c_STEP, c_MAX); m_mode = 2; m_settle = c_HOLD;
            end else begin
                m_atmax = 1;
            end
        end else begin
            m_quiet = min2(m_quiet + 1, c_REL);
            if (m_quiet >= c_REL && m_atten > 0) begin
                m_atten = m_atten - 1; m_atmax = 0; m_quiet = 0; m_mode = 2; m_settle = c_HOLD;
            end
        end
        m_upd = (m_atten != prev) ? 1 : 0;
    endtask

    task automatic tick(input bit rstn, input bit en, input bit vld, input bit od, input int man);
        resetn = rstn; enable = en; valid = vld; overdrive = od; manual_atten = c_AB'(man);
        @(posedge clk);
        model_step(rstn, en, vld, od, man);
        cyc++;
        #1;
    endtask

    function automatic logic [8:0] exp_vec();
        int mm, ma, mx, mu;
        mm = m_mode; ma = m_atten; mx = m_atmax; mu = m_upd;
        return {mm[1:0], mx[0], mu[0], ma[4:0]};
    endfunction

    task automatic test_reset();
        tick(0, 0, 0, 0, 0);
        tick(0, 0, 1, 1, 9);
        total++;
        if ({state, at_max, atten_update, atten} !== 9'd0) begin
            bad++;
            $display("FAIL reset {state,max,upd,atten} got=%b want=%b", {state, at_max, atten_update, atten}, 9'd0);
        end
    endtask

    task automatic test_single_event();
        tick(1, 1, 0, 0, 0);
        tick(1, 1, 1, 1, 0);
        total++;
        if (atten !== 5'd2 || atten_update !== 1'b1 || state !== 2'b10) begin
            bad++;
            $display("FAIL single_event step atten=%0d upd=%b state=%b want 2/1/10", atten, atten_update, state);
        end
        for (int i = 0; i < 6; i++) begin
            tick(1, 1, 0, 0, 0);
            total++;
            if ({state, at_max, atten_update, atten} !== exp_vec()) begin
                bad++;
                $display("FAIL single_event cyc=%0d got=%b want=%b", cyc, {state, at_max, atten_update, atten}, exp_vec());
            end
        end
        total++;
        if (state !== 2'b01) begin
            bad++;
            $display("FAIL settle_exit state got=%b want=01", state);
        end
    endtask

    task automatic test_saturate();
        int ups;
        ups = 0;
        tick(0, 0, 0, 0, 0);
        tick(1, 1, 0, 0, 0);
        for (int i = 0; i < 40; i++) begin
            tick(1, 1, 1, 1, 0);
            ups += atten_update;
            total++;
            if ({state, at_max, atten_update, atten} !== exp_vec()) begin
                bad++;
                $display("FAIL saturate cyc=%0d got=%b want=%b", cyc, {state, at_max, atten_update, atten}, exp_vec());
            end
        end
        total++;
        if (atten !== 5'd7 || at_max !== 1'b1 || ups != 4) begin
            bad++;
            $display("FAIL saturate_end atten=%0d at_max=%b updates=%0d want 7/1/4", atten, at_max, ups);
        end
    endtask

    task automatic test_release();
        int ups;
        ups = 0;
        for (int i = 0; i < 200; i++) begin
            tick(1, 1, 0, 0, 0);
            ups += atten_update;
            total++;
            if ({state, at_max, atten_update, atten} !== exp_vec()) begin
                bad++;
                $display("FAIL release cyc=%0d got=%b want=%b", cyc, {state, at_max, atten_update, atten}, exp_vec());
            end
        end
        total++;
        if (atten !== 5'd0 || at_max !== 1'b0 || ups != 7) begin
            bad++;
            $display("FAIL release_end atten=%0d at_max=%b updates=%0d want 0/0/7", atten, at_max, ups);
        end
    endtask

    task automatic test_invalid_overdrive();
        int ups;
        ups = 0;
        tick(1, 0, 0, 0, 3);
        tick(1, 1, 0, 0, 3);
        for (int i = 0; i < 100; i++) begin
            tick(1, 1, 0, 1, 3);
            ups += atten_update;
            total++;
            if ({state, at_max, atten_update, atten} !== exp_vec()) begin
                bad++;
                $display("FAIL invalid_od cyc=%0d got=%b want=%b", cyc, {state, at_max, atten_update, atten}, exp_vec());
            end
        end
        total++;
        if (atten !== 5'd0 || ups != 3) begin
            bad++;
            $display("FAIL invalid_od_end atten=%0d updates=%0d want 0/3", atten, ups);
        end
    endtask

    task automatic test_mode_switch();
        tick(1, 0, 0, 0, 3);
        tick(1, 1, 0, 0, 3);
        tick(1, 0, 1, 1, 5);
        total++;
        if (atten !== 5'd5 || state !== 2'b00 || atten_update !== 1'b1) begin
            bad++;
            $display("FAIL mode_switch atten=%0d state=%b upd=%b want 5/00/1", atten, state, atten_update);
        end
        tick(1, 0, 0, 0, 20);
        total++;
        if (atten !== 5'd7 || atten_update !== 1'b1) begin
            bad++;
            $display("FAIL manual_clamp atten=%0d upd=%b want 7/1", atten, atten_update);
        end
        tick(1, 0, 0, 0, 20);
        total++;
        if (atten_update !== 1'b0 || atten !== 5'd7) begin
            bad++;
            $display("FAIL manual_hold atten=%0d upd=%b want 7/0", atten, atten_update);
        end
    endtask

    task automatic test_reset_mid_settle();
        tick(1, 0, 0, 0, 2);
        tick(1, 1, 0, 0, 2);
        tick(1, 1, 1, 1, 2);
        tick(1, 1, 0, 0, 2);
        total++;
        if (atten !== 5'd4 || state !== 2'b10) begin
            bad++;
            $display("FAIL pre_reset atten=%0d state=%b want 4/10", atten, state);
        end
        tick(0, 1, 1, 1, 2);
        total++;
        if ({state, at_max, atten_update, atten} !== 9'd0) begin
            bad++;
            $display("FAIL reset_mid_settle got=%b want=%b", {state, at_max, atten_update, atten}, 9'd0);
        end
    endtask

    task automatic test_random();
        bit en, rstn, vld, od;
        int thr, prev_atten;
        en = 1'b1;
        thr = 5;
        prev_atten = atten;
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0) thr = $urandom_range(0, 3) * 12;
            if ($urandom_range(0, 79) == 0) en = ~en;
            rstn = ($urandom_range(0, 399) != 0);
            vld  = $urandom_range(0, 1);
            od   = ($urandom_range(0, 99) < thr);
            tick(rstn, en, vld, od, $urandom_range(0, 31));
            total++;
            if ({state, at_max, atten_update, atten} !== exp_vec()) begin
                bad++;
                $display("FAIL random cyc=%0d got=%b want=%b", cyc, {state, at_max, atten_update, atten}, exp_vec());
            end
            if (rstn) begin
                total++;
                if (atten_update !== (int'(atten) != prev_atten)) begin
                    bad++;
                    $display("FAIL random_upd cyc=%0d upd=%b atten %0d->%0d", cyc, atten_update, prev_atten, atten);
                end
            end
            prev_atten = atten;
        end
    endtask

    initial begin
        resetn = 1'b0; enable = 1'b0; valid = 1'b0; overdrive = 1'b0; manual_atten = '0;
        m_mode = 0; m_atten = 0; m_quiet = 0; m_settle = 0; m_atmax = 0; m_upd = 0;
        test_reset();
        test_single_event();
        test_saturate();
        test_release();
        test_invalid_overdrive();
        test_mode_switch();
        test_reset_mid_settle();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
